// File: rtl/mem_wb_elastic_reg.sv
// rtl/mem_wb_elastic_reg.sv - MEM/WB pipeline register with valid/ready skid buffer and load lane extraction
//
// Purpose:
//   Elastic MEM/WB register. An output register O feeds the WB stage. A skid
//   register S absorbs one extra entry, so in_ready can be a flop and never
//   depends combinationally on out_ready. Load data is lane-extracted and
//   sign/zero-extended before it is stored. A misaligned access becomes an
//   exception bubble.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush               drop held entries and the entry offered this cycle
//   in_valid/in_ready   upstream handshake (MEM stage)
//   in_pc .. in_data    pipeline payload from MEM
//   in_miss_align       misaligned access; replaces the payload with an exception
//   in_load_size        0 byte, 1 half, 2 word, 3 pass-through
//   in_load_sext        sign-extend sub-word loads
//   in_byte_off         byte offset of the access inside the data word
//   out_valid/out_ready downstream handshake (WB stage)
//   out_pc .. out_data  registered payload to WB
module mem_wb_elastic_reg #(
    parameter int DW = 32,
    parameter int AW = 30,
    parameter int RW = 5,
    parameter int CW = 2,
    parameter int EW = 3,
    parameter logic [EW-1:0] EXP_MISS_ALIGN = 'h3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_pc,
    input  logic                      in_en,
    input  logic                      in_br_flag,
    input  logic [CW-1:0]             in_ctrl_op,
    input  logic [RW-1:0]             in_dst_addr,
    input  logic                      in_gpr_we_,
    input  logic [EW-1:0]             in_exp_code,
    input  logic [DW-1:0]             in_data,
    input  logic                      in_miss_align,
    input  logic [1:0]                in_load_size,
    input  logic                      in_load_sext,
    input  logic [$clog2(DW/8)-1:0]   in_byte_off,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AW-1:0]             out_pc,
    output logic                      out_en,
    output logic                      out_br_flag,
    output logic [CW-1:0]             out_ctrl_op,
    output logic [RW-1:0]             out_dst_addr,
    output logic                      out_gpr_we_,
    output logic [EW-1:0]             out_exp_code,
    output logic [DW-1:0]             out_data
);

    localparam int OW = $clog2(DW/8);
    // Width of the "word" load: 32 bits, or the whole data word when narrower.
    localparam int WW = (DW > 32) ? 32 : DW;
    // Packed payload: {pc, en, br_flag, ctrl_op, dst_addr, gpr_we_, exp_code, data}
    localparam int PW = AW + 3 + CW + RW + EW + DW;
    // Half loads ignore offset bit 0; word loads ignore bits [1:0] (and use no offset at all when DW <= 32).
    localparam logic [OW-1:0] HALF_MASK = ~OW'(1);
    localparam logic [OW-1:0] WORD_MASK = (DW > 32) ? ~OW'(3) : '0;
    // Idle payload: everything zero except the active-low write enable.
    localparam logic [PW-1:0] RESET_PL = PW'(1) << (EW + DW);

    logic [PW-1:0] o_q, o_d, s_q, s_d;
    logic          o_valid_q, o_valid_d, s_valid_q, s_valid_d;

    logic [OW-1:0] sh_off;
    logic [DW-1:0] shifted;
    logic [DW-1:0] ext_data;
    logic [PW-1:0] new_pl;
    logic          accept, pop;

    always_comb begin
        sh_off = '0;
        case (in_load_size)
            2'd0:    sh_off = in_byte_off;
            2'd1:    sh_off = in_byte_off & HALF_MASK;
            2'd2:    sh_off = in_byte_off & WORD_MASK;
            default: sh_off = '0;
        endcase
    end

    // Bring the selected lane down to bit 0, then extend from its top bit.
    assign shifted = in_data >> {sh_off, 3'b000};

    always_comb begin
        ext_data = in_data;
        case (in_load_size)
            2'd0: ext_data = in_load_sext ? DW'($signed(shifted[7:0]))    : DW'(shifted[7:0]);
            2'd1: ext_data = in_load_sext ? DW'($signed(shifted[15:0]))   : DW'(shifted[15:0]);
            2'd2: ext_data = in_load_sext ? DW'($signed(shifted[WW-1:0])) : DW'(shifted[WW-1:0]);
            default: ext_data = in_data;
        endcase
    end

    // A misaligned access keeps its pc/en/br_flag for the exception handler and becomes a no-write bubble.
    always_comb begin
        if (in_miss_align) begin
            new_pl = {in_pc, in_en, in_br_flag, {CW{1'b0}}, {RW{1'b0}}, 1'b1,
                      EXP_MISS_ALIGN, {DW{1'b0}}};
        end else begin
            new_pl = {in_pc, in_en, in_br_flag, in_ctrl_op, in_dst_addr, in_gpr_we_,
                      in_exp_code, ext_data};
        end
    end

    assign in_ready  = !s_valid_q;
    assign out_valid = o_valid_q;
    assign accept    = in_valid && in_ready;
    assign pop       = o_valid_q && out_ready;

    // When S is full in_ready is low, so "pop with S full" never coincides with an accept.
    always_comb begin
        o_d       = o_q;
        s_d       = s_q;
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            o_d       = RESET_PL;
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (pop && s_valid_q) begin
            o_d       = s_q;
            s_valid_d = 1'b0;
        end else if (accept && (!o_valid_q || pop)) begin
            o_d       = new_pl;
            o_valid_d = 1'b1;
        end else if (accept) begin
            s_d       = new_pl;
            s_valid_d = 1'b1;
        end else if (pop) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q       <= RESET_PL;
            s_q       <= RESET_PL;
            o_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            o_q       <= o_d;
            s_q       <= s_d;
            o_valid_q <= o_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign {out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr, out_gpr_we_,
            out_exp_code, out_data} = o_q;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// tb/tb_mem_wb_elastic_reg.sv - self-checking bench for mem_wb_elastic_reg (queue model plus directed literals)
module tb_mem_wb_elastic_reg;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] data;
    } pl_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [29:0] in_pc;
    logic        in_en, in_br_flag;
    logic [1:0]  in_ctrl_op;
    logic [4:0]  in_dst_addr;
    logic        in_gpr_we_;
    logic [2:0]  in_exp_code;
    logic [31:0] in_data;
    logic        in_miss_align;
    logic [1:0]  in_load_size;
    logic        in_load_sext;
    logic [1:0]  in_byte_off;
    logic        out_valid, out_ready;
    logic [29:0] out_pc;
    logic        out_en, out_br_flag;
    logic [1:0]  out_ctrl_op;
    logic [4:0]  out_dst_addr;
    logic        out_gpr_we_;
    logic [2:0]  out_exp_code;
    logic [31:0] out_data;

    mem_wb_elastic_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_en(in_en), .in_br_flag(in_br_flag),
        .in_ctrl_op(in_ctrl_op), .in_dst_addr(in_dst_addr), .in_gpr_we_(in_gpr_we_),
        .in_exp_code(in_exp_code), .in_data(in_data), .in_miss_align(in_miss_align),
        .in_load_size(in_load_size), .in_load_sext(in_load_sext), .in_byte_off(in_byte_off),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_en(out_en), .out_br_flag(out_br_flag),
        .out_ctrl_op(out_ctrl_op), .out_dst_addr(out_dst_addr), .out_gpr_we_(out_gpr_we_),
        .out_exp_code(out_exp_code), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: the block is a 2-deep FIFO of processed payloads.
    pl_t         q[$];
    logic [29:0] seen[$];
    bit          live   = 0;
    bit          rst_pl = 0;
    bit          m_pop, m_acc;

    function automatic pl_t mk();
        pl_t         p;
        logic [31:0] v;
        p.pc = in_pc;
        p.en = in_en;
        p.br = in_br_flag;
        if (in_miss_align) begin
            p.ctrl = 0; p.dst = 0; p.we_ = 1; p.exp = 3; p.data = 0;
        end else begin
            p.ctrl = in_ctrl_op; p.dst = in_dst_addr; p.we_ = in_gpr_we_; p.exp = in_exp_code;
            case (in_load_size)
                2'd0: begin
                    v = (in_data >> (8 * in_byte_off)) & 32'hFF;
                    if (in_load_sext && v[7]) v = v | 32'hFFFFFF00;
                end
                2'd1: begin
                    v = (in_data >> (16 * in_byte_off[1])) & 32'hFFFF;
                    if (in_load_sext && v[15]) v = v | 32'hFFFF0000;
                end
                default: v = in_data;
            endcase
            p.data = v;
        end
        return p;
    endfunction

    function automatic pl_t rst_val();
        pl_t r;
        r     = '0;
        r.we_ = 1'b1;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        if (live && out_valid && out_ready) seen.push_back(out_pc);
        if (reset || flush) begin
            q.delete();
            rst_pl = 1;
            live   = 1;
        end else if (live) begin
            m_pop = (q.size() > 0) && out_ready;
            m_acc = in_valid && (q.size() < 2);
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(mk());
                rst_pl = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("model_valid", out_valid, q.size() > 0);
            chk("model_ready", in_ready, q.size() < 2);
            if (q.size() > 0)
                chk("model_payload", {out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr,
                                      out_gpr_we_, out_exp_code, out_data}, q[0]);
            else if (rst_pl)
                chk("model_rst_payload", {out_pc, out_en, out_br_flag, out_ctrl_op, out_dst_addr,
                                          out_gpr_we_, out_exp_code, out_data}, rst_val());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic set_in(input logic [29:0] pc, input logic [31:0] d, input logic [1:0] sz,
                          input logic [1:0] off, input logic sx);
        in_valid = 1; in_pc = pc; in_data = d; in_load_size = sz; in_byte_off = off; in_load_sext = sx;
    endtask

    logic [31:0] ext_d[6]  = '{32'h80F17F22, 32'h80F17F22, 32'h80F17F22, 32'h80F17F22, 32'h80F17F22, 32'h80F17F22};
    logic [1:0]  ext_sz[6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
    logic [1:0]  ext_of[6] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
    logic        ext_sx[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ext_ex[6] = '{32'h0000007F, 32'hFFFFFFF1, 32'h000080F1, 32'hFFFF80F1, 32'h80F17F22, 32'h00000022};

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_pc = 0; in_en = 1; in_br_flag = 0; in_ctrl_op = 0; in_dst_addr = 1; in_gpr_we_ = 0;
        in_exp_code = 0; in_data = 0; in_miss_align = 0; in_load_size = 3; in_load_sext = 0; in_byte_off = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_gpr_we_", out_gpr_we_, 1);
        chk("rst_data", out_data, 0);

        // Streaming at full rate
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_in(30'h10 + 30'(i), 32'h1000 + 32'(i), 2'd3, 2'd0, 1'b0);
            @(negedge clk);
            chk("stream_valid", out_valid, 1);
            chk("stream_pc", out_pc, 30'h10 + 30'(i));
        end
        in_valid = 0;
        @(negedge clk);

        // Backpressure: A and B fill O and S, C waits
        seen.delete();
        out_ready = 0;
        set_in(30'h20, 32'hA, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        set_in(30'h21, 32'hB, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        set_in(30'h22, 32'hC, 2'd3, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("bp_hold_pc", out_pc, 30'h20);
        out_ready = 1;
        begin
            int k = 0;
            while (in_ready !== 1'b1 && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("bp_ready_timeout", k < 10, 1);
        end
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        chk("bp_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("bp_order0", seen[0], 30'h20);
            chk("bp_order1", seen[1], 30'h21);
            chk("bp_order2", seen[2], 30'h22);
        end

        // Lane extraction
        for (int i = 0; i < 6; i++) begin
            set_in(30'h30 + 30'(i), ext_d[i], ext_sz[i], ext_of[i], ext_sx[i]);
            @(negedge clk);
            chk("ext_data", out_data, ext_ex[i]);
        end
        in_valid = 0;
        @(negedge clk);

        // Misalignment override
        set_in(30'h40, 32'h1234, 2'd2, 2'd1, 1'b0);
        in_miss_align = 1; in_dst_addr = 7; in_gpr_we_ = 0; in_ctrl_op = 2; in_br_flag = 1;
        @(negedge clk);
        chk("ma_pc", out_pc, 30'h40);
        chk("ma_dst", out_dst_addr, 0);
        chk("ma_we_", out_gpr_we_, 1);
        chk("ma_ctrl", out_ctrl_op, 0);
        chk("ma_exp", out_exp_code, 3);
        chk("ma_data", out_data, 0);
        chk("ma_br", out_br_flag, 1);
        in_valid = 0; in_miss_align = 0; in_dst_addr = 1; in_ctrl_op = 0; in_br_flag = 0;
        @(negedge clk);

        // Flush with O and S full plus an incoming entry
        seen.delete();
        out_ready = 0;
        set_in(30'h50, 32'h50, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        set_in(30'h51, 32'h51, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        set_in(30'h52, 32'h52, 2'd3, 2'd0, 1'b0);
        flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_pc", out_pc, 0);
        out_ready = 1;
        repeat (4) @(negedge clk);
        chk("fl_never_seen", seen.size(), 0);

        // Reset mid-stream with S full
        out_ready = 0;
        set_in(30'h60, 32'h60, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        set_in(30'h61, 32'h61, 2'd3, 2'd0, 1'b0);
        @(negedge clk);
        chk("mr_s_full", in_ready, 0);
        reset = 1; in_valid = 0;
        @(negedge clk);
        reset = 0;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_gpr_we_", out_gpr_we_, 1);
        chk("mr_data", out_data, 0);

        // Mixed handshake pattern, checked by the model
        for (int i = 0; i < 40; i++) begin
            set_in(30'h100 + 30'(i), 32'h8F3C5A17 ^ (32'(i) * 32'h01010101),
                   2'(i % 4), 2'((i / 4) % 4), 1'(i % 2));
            in_valid      = (i % 4) != 3;
            out_ready     = (i % 3) != 0;
            in_miss_align = (i % 11) == 5;
            in_dst_addr   = 5'(i);
            in_gpr_we_    = 1'(i % 2);
            in_exp_code   = 3'(i % 3);
            in_ctrl_op    = 2'(i % 4);
            @(negedge clk);
        end
        in_valid = 0; in_miss_align = 0; out_ready = 1;
        repeat (4) @(negedge clk);
        chk("drain_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
